// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared MAR/MDR memory port: arbitrates fetch (port 0)
// and data (port 1), sequences the memory handshake and reports ack/err with read data.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 15,
  parameter int FIXED_PRI = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            rw,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            grant,
  output logic [1:0]            ack,
  output logic [1:0]            err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     mar_out,
  output logic                  mar_in,
  output logic [DATA_W-1:0]     mdr_wdata,
  output logic                  memEN,
  output logic                  RW,
  input  logic                  MFC,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_CAPTURE,
    S_ACK,
    S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic             owner;
  logic             last_grant;
  logic             rw_lat;
  logic [CNT_W-1:0] cnt;
  logic             win;
  logic             timeout_hit;
  logic [1:0]       owner_oh;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = (FIXED_PRI != 0) ? 1'b0 : ~last_grant;
      default: win = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req != 2'b00) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (MFC)              state_nxt = S_CAPTURE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_CAPTURE: state_nxt = S_ACK;
      S_ACK:     state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset drops them immediately.
  always_comb begin
    owner_oh = owner ? 2'b10 : 2'b01;
    busy     = (state != S_IDLE);
    mar_in   = (state == S_SETUP);
    memEN    = (state == S_ACCESS);
    RW       = rw_lat && ((state == S_SETUP) || (state == S_ACCESS) || (state == S_CAPTURE));
    grant    = busy ? owner_oh : 2'b00;
    ack      = (state == S_ACK) ? owner_oh : 2'b00;
    err      = (state == S_ERR) ? owner_oh : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rw_lat     <= 1'b0;
      mar_out    <= '0;
      mdr_wdata  <= '0;
      rdata      <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            owner      <= win;
            last_grant <= win;
            rw_lat     <= win ? rw[1] : rw[0];
            mar_out    <= win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            mdr_wdata  <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
          end
        end
        S_SETUP: cnt <= '0;
        S_ACCESS: begin
          if (MFC && rw_lat) rdata <= mem_rdata;
          if (TIMEOUT != 0)  cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority instance
// share stimulus; each task drives one scenario and checks against hand-derived values.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  rw;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        MFC;
  logic [15:0] mem_rdata;

  logic [1:0]  grant, ack, err;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  mar_out;
  logic        mar_in;
  logic [15:0] mdr_wdata;
  logic        memEN, RW;

  logic [1:0]  grant_fp, ack_fp, err_fp;
  logic [15:0] rdata_fp;
  logic        busy_fp;
  logic [7:0]  mar_out_fp;
  logic        mar_in_fp;
  logic [15:0] mdr_wdata_fp;
  logic        memEN_fp, RW_fp;

  int checks = 0;
  int errors = 0;

  int          o_edges;
  logic [1:0]  o_grant, o_grant_fp, o_ack, o_err;
  int          o_memen, o_marin, o_both;
  logic [7:0]  o_mar;
  logic [15:0] o_mdr, o_rdata;
  logic        o_rw, o_busy_after;
  logic [1:0]  o_pulse_after;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .grant(grant), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mar_out(mar_out), .mar_in(mar_in), .mdr_wdata(mdr_wdata), .memEN(memEN),
    .RW(RW), .MFC(MFC), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(15), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .grant(grant_fp), .ack(ack_fp), .err(err_fp), .rdata(rdata_fp), .busy(busy_fp),
    .mar_out(mar_out_fp), .mar_in(mar_in_fp), .mdr_wdata(mdr_wdata_fp), .memEN(memEN_fp),
    .RW(RW_fp), .MFC(MFC), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plays the memory side of one transaction: MFC rises in ACCESS cycle mfc_wait
  // (0-based, -1 = never). o_edges counts edges from the latching edge to ack/err.
  task automatic run_txn(input int mfc_wait, input bit drop_req);
    int  acc;
    bit  done;
    acc = 0; done = 0;
    o_edges = -1; o_grant = 2'b00; o_grant_fp = 2'b00; o_ack = 2'b00; o_err = 2'b00;
    o_memen = 0; o_marin = 0; o_both = 0; o_mar = 8'h00; o_mdr = 16'h0; o_rw = 1'bx;
    o_rdata = 16'hxxxx; o_busy_after = 1'bx; o_pulse_after = 2'bxx;
    MFC = 1'b0;
    for (int e = 1; e <= 40 && !done; e++) begin
      @(posedge clk); #1;
      if (mar_in) begin
        o_marin++;
        o_grant = grant; o_grant_fp = grant_fp;
        o_mar = mar_out; o_mdr = mdr_wdata; o_rw = RW;
      end
      if (memEN) begin
        MFC = (mfc_wait >= 0) && (acc >= mfc_wait);
        acc++;
        o_memen++;
      end else begin
        MFC = 1'b0;
      end
      if (ack != 2'b00 && err != 2'b00) o_both++;
      if (ack != 2'b00 || err != 2'b00) begin
        o_ack = ack; o_err = err; o_rdata = rdata; o_edges = e; done = 1;
      end
    end
    if (done) begin
      @(posedge clk); #1;
      o_busy_after  = busy;
      o_pulse_after = ack | err;
      if (drop_req) req = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; rw = 2'b00; addr = 16'h0; wdata = 32'h0;
    MFC = 1'b0; mem_rdata = 16'h0;
    #3;
    checks++; if ({grant, ack, err} !== 6'b0) begin errors++;
      $display("[TB] FAIL reset_grant_ack_err: got %b expected 000000", {grant, ack, err}); end
    checks++; if ({busy, memEN, mar_in, RW} !== 4'b0) begin errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {busy, memEN, mar_in, RW}); end
    checks++; if (rdata !== 16'h0) begin errors++;
      $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); end
    checks++; if (mar_out !== 8'h0 || mdr_wdata !== 16'h0) begin errors++;
      $display("[TB] FAIL reset_latches: got mar=%h mdr=%h expected 00/0000", mar_out, mdr_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("[TB] FAIL idle_no_req_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_read();
    addr = {8'h77, 8'h12}; wdata = 32'h0; rw = 2'b11; mem_rdata = 16'hBEEF; req = 2'b01;
    run_txn(0, 1'b1);
    checks++; if (o_grant !== 2'b01) begin errors++;
      $display("[TB] FAIL read_grant: got %b expected 01", o_grant); end
    checks++; if (o_marin !== 1 || o_mar !== 8'h12) begin errors++;
      $display("[TB] FAIL read_mar: got pulses=%0d mar=%h expected 1/12", o_marin, o_mar); end
    checks++; if (o_rw !== 1'b1 || o_memen !== 1) begin errors++;
      $display("[TB] FAIL read_rw_memen: got rw=%b memen=%0d expected 1/1", o_rw, o_memen); end
    checks++; if (o_edges !== 4) begin errors++;
      $display("[TB] FAIL read_ack_latency: got %0d expected 4", o_edges); end
    checks++; if (o_ack !== 2'b01 || o_err !== 2'b00) begin errors++;
      $display("[TB] FAIL read_ack: got ack=%b err=%b expected 01/00", o_ack, o_err); end
    checks++; if (o_rdata !== 16'hBEEF) begin errors++;
      $display("[TB] FAIL read_rdata: got %h expected beef", o_rdata); end
    checks++; if (o_busy_after !== 1'b0 || o_pulse_after !== 2'b00) begin errors++;
      $display("[TB] FAIL read_return_idle: got busy=%b pulse=%b expected 0/00", o_busy_after, o_pulse_after); end
  endtask

  task automatic test_write();
    addr = {8'h40, 8'h99}; wdata = {16'h1234, 16'h5555}; rw = 2'b01; mem_rdata = 16'hAAAA; req = 2'b10;
    run_txn(3, 1'b1);
    checks++; if (o_grant !== 2'b10) begin errors++;
      $display("[TB] FAIL write_grant: got %b expected 10", o_grant); end
    checks++; if (o_mar !== 8'h40 || o_mdr !== 16'h1234) begin errors++;
      $display("[TB] FAIL write_latch: got mar=%h mdr=%h expected 40/1234", o_mar, o_mdr); end
    checks++; if (o_rw !== 1'b0) begin errors++;
      $display("[TB] FAIL write_rw: got %b expected 0", o_rw); end
    checks++; if (o_memen !== 4) begin errors++;
      $display("[TB] FAIL write_memen_cycles: got %0d expected 4", o_memen); end
    checks++; if (o_edges !== 7 || o_ack !== 2'b10) begin errors++;
      $display("[TB] FAIL write_ack: got latency=%0d ack=%b expected 7/10", o_edges, o_ack); end
    checks++; if (o_rdata !== 16'hBEEF) begin errors++;
      $display("[TB] FAIL write_rdata_held: got %h expected beef", o_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr;
    addr = {8'h21, 8'h20}; rw = 2'b11; mem_rdata = 16'h0F0F; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_rr = (i % 2 == 0) ? 2'b01 : 2'b10;
      run_txn(0, i == 3);
      checks++; if (o_grant !== exp_rr || o_ack !== exp_rr) begin errors++;
        $display("[TB] FAIL rr_grant_%0d: got grant=%b ack=%b expected %b", i, o_grant, o_ack, exp_rr); end
      checks++; if (o_grant_fp !== 2'b01) begin errors++;
        $display("[TB] FAIL fixed_grant_%0d: got %b expected 01", i, o_grant_fp); end
    end
  endtask

  task automatic test_timeout();
    rw = 2'b01; mem_rdata = 16'hDEAD; req = 2'b01;
    run_txn(-1, 1'b1);
    checks++; if (o_memen !== 15) begin errors++;
      $display("[TB] FAIL timeout_memen_cycles: got %0d expected 15", o_memen); end
    checks++; if (o_err !== 2'b01 || o_ack !== 2'b00) begin errors++;
      $display("[TB] FAIL timeout_err: got err=%b ack=%b expected 01/00", o_err, o_ack); end
    checks++; if (o_edges !== 17 || o_both !== 0) begin errors++;
      $display("[TB] FAIL timeout_latency: got %0d overlap=%0d expected 17/0", o_edges, o_both); end
    checks++; if (o_rdata !== 16'h0F0F) begin errors++;
      $display("[TB] FAIL timeout_rdata_held: got %h expected 0f0f", o_rdata); end
    checks++; if (o_busy_after !== 1'b0 || o_pulse_after !== 2'b00) begin errors++;
      $display("[TB] FAIL timeout_return_idle: got busy=%b pulse=%b expected 0/00", o_busy_after, o_pulse_after); end
  endtask

  task automatic test_timeout_edge();
    rw = 2'b11; mem_rdata = 16'hCAFE; req = 2'b10;
    run_txn(14, 1'b1);
    checks++; if (o_ack !== 2'b10 || o_err !== 2'b00) begin errors++;
      $display("[TB] FAIL mfc_on_timeout_edge: got ack=%b err=%b expected 10/00", o_ack, o_err); end
    checks++; if (o_memen !== 15 || o_edges !== 18) begin errors++;
      $display("[TB] FAIL mfc_edge_timing: got memen=%0d latency=%0d expected 15/18", o_memen, o_edges); end
    checks++; if (o_rdata !== 16'hCAFE) begin errors++;
      $display("[TB] FAIL mfc_edge_rdata: got %h expected cafe", o_rdata); end
  endtask

  task automatic test_async_reset();
    addr = {8'h44, 8'h33}; rw = 2'b11; MFC = 1'b0; req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (memEN !== 1'b1) begin errors++;
      $display("[TB] FAIL pre_reset_access: got memEN=%b expected 1", memEN); end
    #2; rst = 1'b1; #1;
    checks++; if (memEN !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL async_reset_drop: got memEN=%b grant=%b busy=%b expected 0/00/0", memEN, grant, busy); end
    #1; rst = 1'b0; req = 2'b11; mem_rdata = 16'h5A5A;
    run_txn(0, 1'b1);
    checks++; if (o_grant !== 2'b01 || o_marin !== 1) begin errors++;
      $display("[TB] FAIL post_reset_tie: got grant=%b setup=%0d expected 01/1", o_grant, o_marin); end
    checks++; if (o_ack !== 2'b01 || o_edges !== 4 || o_rdata !== 16'h5A5A) begin errors++;
      $display("[TB] FAIL post_reset_read: got ack=%b latency=%0d rdata=%h expected 01/4/5a5a", o_ack, o_edges, o_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_timeout_edge();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
